// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined ALU with a valid/ready handshake on both
//            sides. It accepts one operation per cycle and returns each
//            result and its flags two cycles after the operation is accepted.
//            The pipeline supports full backpressure.
// Options  : ALU_SAT_EN - unsigned saturation for ADD/SUB.
//            Undefined by default, in which case ADD/SUB wrap.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;

    // Shift amounts at or above this value flush every bit out of the result.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);
    localparam int               MSB         = WIDTH - 1;

    // Pipeline state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_sel;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_carry;
    logic             s2_overflow;
    logic             s2_zero;
    logic             s2_negative;

    // Handshake controls
    logic             s2_load;
    logic             in_fire;

    // Stage-2 combinational results
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_overflow;

    // Stage 2 advances whenever it is empty or its content is being consumed.
    // Stage 1 advances whenever it is empty or drains into stage 2.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Stage-1 occupancy is cleared asynchronously so that in-flight ops are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 operand capture happens only on an input transfer; no reset is needed.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_sel <= sel;
        end
    end

    // ALU datapath operating on the stage-1 operands.
    always_comb begin
        sum          = {1'b0, s1_a} + {1'b0, s1_b};
        diff         = {1'b0, s1_a} - {1'b0, s1_b};
        res          = '0;
        res_carry    = 1'b0;
        res_overflow = 1'b0;
        case (s1_sel)
            OP_ADD: begin
                res          = sum[WIDTH-1:0];
                res_carry    = sum[WIDTH];
                res_overflow = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
`ifdef ALU_SAT_EN
                if (res_carry) begin
                    res = '1;
                end
                res_overflow = 1'b0;
`endif
            end
            OP_SUB: begin
                res          = diff[WIDTH-1:0];
                res_carry    = diff[WIDTH];
                res_overflow = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
`ifdef ALU_SAT_EN
                if (res_carry) begin
                    res = '0;
                end
                res_overflow = 1'b0;
`endif
            end
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_SHL:  res = (s1_b >= SHIFT_LIMIT) ? '0 : (s1_a << s1_b);
            OP_SHR:  res = (s1_b >= SHIFT_LIMIT) ? '0 : (s1_a >> s1_b);
            default: res = s1_b;
        endcase
    end

    // Stage-2 occupancy is cleared asynchronously alongside stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
        end
    end

    // Stage-2 result registers load only with a real op, so held output stays untouched while stalled.
    always_ff @(posedge clk) begin
        if (s2_load && s1_valid) begin
            s2_y        <= res;
            s2_carry    <= res_carry;
            s2_overflow <= res_overflow;
            s2_zero     <= (res == '0);
            s2_negative <= res[MSB];
        end
    end

    // Outputs are masked by s2_valid so that unreset data never reaches the consumer.
    assign out_valid = s2_valid;
    assign Y         = s2_y & {WIDTH{s2_valid}};
    assign carry     = s2_carry    && s2_valid;
    assign overflow  = s2_overflow && s2_valid;
    assign zero      = s2_zero     && s2_valid;
    assign negative  = s2_negative && s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe. It drives an 8-bit instance
//            from a vector table, runs random traffic, and runs backpressure
//            and reset sequences. A 4-bit instance runs a back-to-back
//            sequence. Results are checked through an in-order scoreboard.
// Options  : ALU_SAT_EN selects the saturating expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    // 8-bit instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [2:0] sel8;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y8;
    logic       carry, overflow, zero, negative;

    // 4-bit instance
    logic       w4_in_valid;
    logic       w4_in_ready;
    logic [3:0] w4_a;
    logic [3:0] w4_b;
    logic [2:0] w4_sel;
    logic       w4_out_valid;
    logic [3:0] w4_y;
    logic       w4_c, w4_v, w4_z, w4_n;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a8), .B(b8), .sel(sel8), .out_valid(out_valid), .out_ready(out_ready),
        .Y(y8), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
    );

    alu_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .A(w4_a), .B(w4_b), .sel(w4_sel), .out_valid(w4_out_valid), .out_ready(1'b1),
        .Y(w4_y), .carry(w4_c), .overflow(w4_v), .zero(w4_z), .negative(w4_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready control: 0 = held high, 1 = held low, 2 = random per cycle
    int   or_mode = 0;
    logic rnd_bit = 1'b1;
    always begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign out_ready = (or_mode == 2) ? rnd_bit : (or_mode == 0);

    // Independent reference model: returns {carry, overflow, zero, negative, Y}
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ua, ub, sa, sb, r;
        logic [7:0] y;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; y = 8'h00; r = 0;
        case (op)
            3'd0: begin
                r = ua + ub; y = r[7:0]; c = (r > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
`ifdef ALU_SAT_EN
                if (c) y = 8'hFF;
                v = 1'b0;
`endif
            end
            3'd1: begin
                r = ua - ub; y = r[7:0]; c = (ua < ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
`ifdef ALU_SAT_EN
                if (c) y = 8'h00;
                v = 1'b0;
`endif
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin r = ua << ub; y = (ub >= 8) ? 8'h00 : r[7:0]; end
            3'd6: y = (ub >= 8) ? 8'h00 : (a >> ub);
            default: y = b;
        endcase
        return {c, v, (y == 8'h00), y[7], y};
    endfunction

    // Scoreboard
    typedef struct {
        logic [11:0] exp;
        int          cyc;
        bit          lat;
    } sb_t;
    sb_t         q[$];
    logic [11:0] cur_exp;
    bit          lat_mode = 1'b0;
    int          cycle = 0;
    int          pops = 0;
    bit          held_v = 1'b0;
    logic [11:0] held;

    // Monitor: output pops, hold stability and input pushes, sampled mid-cycle
    always @(negedge clk) begin
        sb_t e;
        cycle++;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("hold_stable", {19'd0, out_valid, carry, overflow, zero, negative, y8}, {19'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h expected none", {carry, overflow, zero, negative, y8});
                end else begin
                    e = q.pop_front();
                    check("result", {20'd0, carry, overflow, zero, negative, y8}, {20'd0, e.exp});
                    if (e.lat) check("latency", cycle - e.cyc, 2);
                    pops++;
                end
            end
            held_v = out_valid && !out_ready;
            held   = {carry, overflow, zero, negative, y8};
            if (in_valid && in_ready) q.push_back('{cur_exp, cycle, lat_mode});
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [11:0] exp);
        bit acc;
        acc = 1'b0;
        a8 = a; b8 = b; sel8 = op; cur_exp = exp; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no in_ready expected accept");
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        check(name, q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [11:0] exp;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] w4_exp[5];
    logic [11:0] bp_exp[3];
    int         idx;
    int         pops0;

    initial begin
        // Vector table {A, B, sel, {carry, overflow, zero, negative, Y}}
`ifdef ALU_SAT_EN
        tbl[0]  = '{8'hF0, 8'h20, 3'd0, 12'h9FF};
        tbl[1]  = '{8'h03, 8'h05, 3'd1, 12'hA00};
        tbl[5]  = '{8'h7F, 8'h01, 3'd0, 12'h180};
        tbl[6]  = '{8'h80, 8'h01, 3'd1, 12'h07F};
        tbl[15] = '{8'hFF, 8'h01, 3'd0, 12'h9FF};
        w4_exp[0] = 8'b0001_1000;
`else
        tbl[0]  = '{8'hF0, 8'h20, 3'd0, 12'h810};
        tbl[1]  = '{8'h03, 8'h05, 3'd1, 12'h9FE};
        tbl[5]  = '{8'h7F, 8'h01, 3'd0, 12'h580};
        tbl[6]  = '{8'h80, 8'h01, 3'd1, 12'h47F};
        tbl[15] = '{8'hFF, 8'h01, 3'd0, 12'hA00};
        w4_exp[0] = 8'b0101_1000;
`endif
        tbl[2]  = '{8'h81, 8'h01, 3'd5, 12'h002};
        tbl[3]  = '{8'h81, 8'h08, 3'd6, 12'h200};
        tbl[4]  = '{8'h00, 8'h5A, 3'd7, 12'h05A};
        tbl[7]  = '{8'hF0, 8'h3C, 3'd2, 12'h030};
        tbl[8]  = '{8'hF0, 8'h0F, 3'd3, 12'h1FF};
        tbl[9]  = '{8'hAA, 8'hAA, 3'd4, 12'h200};
        tbl[10] = '{8'h80, 8'h07, 3'd6, 12'h001};
        tbl[11] = '{8'h01, 8'h07, 3'd5, 12'h180};
        tbl[12] = '{8'hFF, 8'hC8, 3'd5, 12'h200};
        tbl[13] = '{8'h05, 8'h05, 3'd1, 12'h200};
        tbl[14] = '{8'h12, 8'h34, 3'd7, 12'h034};
        w4_exp[1] = 8'b0000_0010;
        w4_exp[2] = 8'b0000_0001;
        w4_exp[3] = 8'b0000_0111;
        w4_exp[4] = 8'b0000_0110;

        rst = 1'b1; in_valid = 1'b0; a8 = '0; b8 = '0; sel8 = '0; cur_exp = '0;
        w4_in_valid = 1'b0; w4_a = 4'b0101; w4_b = 4'b0011; w4_sel = '0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {carry, overflow, zero, negative, y8}, 12'h000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_idle_out", {out_valid, carry, overflow, zero, negative, y8}, 13'h0000);
        @(posedge clk); #1;

        // 4-bit back-to-back sequence, each result due two cycles after presentation
        for (int c = 0; c < 7; c++) begin
            w4_in_valid = (c < 5);
            w4_sel      = (c < 5) ? 3'(c) : 3'd0;
            @(negedge clk);
            if (c < 5) check("w4_in_ready", w4_in_ready, 1);
            if (c >= 2)
                check("w4_result", {w4_out_valid, w4_c, w4_v, w4_z, w4_n, w4_y}, {1'b1, w4_exp[c-2]});
            else
                check("w4_not_valid", w4_out_valid, 0);
            @(posedge clk); #1;
        end
        w4_in_valid = 1'b0;

        // Table vectors back-to-back with out_ready high
        or_mode = 0; lat_mode = 1'b1;
        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
        drain("table_drain");
        lat_mode = 1'b0;

        // Random traffic with random backpressure
        or_mode = 2;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic [2:0] rop;
            ra  = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            rb  = (rop == 3'd5 || rop == 3'd6) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            send(ra, rb, rop, model(ra, rb, rop));
        end
        or_mode = 0;
        drain("random_drain");

        // Backpressure: three ops offered for six stalled cycles
        or_mode = 1;
        pops0 = pops;
        bp_exp[0] = model(8'h11, 8'h22, 3'd0);
        bp_exp[1] = model(8'h40, 8'h50, 3'd1);
        bp_exp[2] = model(8'h0F, 8'h3C, 3'd4);
        idx = 0;
        a8 = 8'h11; b8 = 8'h22; sel8 = 3'd0; cur_exp = bp_exp[0]; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            case (idx)
                1: begin a8 = 8'h40; b8 = 8'h50; sel8 = 3'd1; cur_exp = bp_exp[1]; end
                2: begin a8 = 8'h0F; b8 = 8'h3C; sel8 = 3'd4; cur_exp = bp_exp[2]; end
                default: ;
            endcase
        end
        check("bp_accepted", idx, 2);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_first", {out_valid, carry, overflow, zero, negative, y8}, {1'b1, bp_exp[0]});
        @(posedge clk); #1;
        or_mode = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("bp_drain");
        check("bp_count", pops - pops0, 3);

        // Reset with two ops in flight
        or_mode = 1;
        send(8'h01, 8'h02, 3'd0, model(8'h01, 8'h02, 3'd0));
        send(8'h03, 8'h04, 3'd3, model(8'h03, 8'h04, 3'd3));
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_flush_valid", out_valid, 0);
        check("rst_flush_data", {carry, overflow, zero, negative, y8}, 12'h000);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        or_mode = 0;
        @(negedge clk);
        check("post_rst_empty", {in_ready, out_valid}, 2'b10);
        @(posedge clk); #1;
        lat_mode = 1'b1;
        send(8'h81, 8'h01, 3'd5, 12'h002);
        drain("post_rst_drain");
        check("post_rst_count", pops - pops0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
